// File: rtl/display_field_scheduler.sv
// display_field_scheduler: round-robin capture of three 16-bit status values
// into shadow registers, tear-free commit to display registers at frame start,
// and rotation of the displayed field every FRAMES_PER_PAGE frames.
// Optional macro DISPLAY_HOLD_EN adds input ihold, which freezes commit and
// rotation while high (arbitration into shadows keeps running).
module display_field_scheduler #(
    parameter int FRAMES_PER_PAGE = 120,
    parameter int CNT_W           = 8,
    parameter int RESET_SEL       = 0
) (
    input  logic        iclock,
    input  logic        ireset_n,
    input  logic        iframe_start,
    input  logic [2:0]  ireq,
    input  logic [15:0] itemperature,
    input  logic [15:0] iautor,
    input  logic [15:0] imusica,
`ifdef DISPLAY_HOLD_EN
    input  logic        ihold,
`endif
    output logic [2:0]  oack,
    output logic [15:0] odisplay_value,
    output logic [1:0]  odisplay_sel,
    output logic        oupdated
);

    typedef enum logic {S_RUN, S_COMMIT} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAMES_PER_PAGE - 1);

    state_t            state_q;
    logic [2:0][15:0]  shadow_q, disp_q, disp_d;
    logic [2:0]        dirty_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        rr_q, sel_q, sel_d;
    logic [2:0]        ack_q;
    logic              upd_q;
    logic [15:0]       val_q;

    logic [2:0]        eligible;
    logic              grant_vld;
    logic [1:0]        win;
    logic [15:0]       win_data;
    logic              hold_w;
    logic              commit_en;
    logic              wrap;
    logic [1:0]        sel_nxt;

`ifdef DISPLAY_HOLD_EN
    assign hold_w = ihold;
`else
    assign hold_w = 1'b0;
`endif

    // A producer still showing its ack this cycle is masked so a slow req drop
    // cannot earn a second grant.
    assign eligible = ireq & ~ack_q;

    // Round-robin winner: first eligible source at or above rr_q, modulo 3.
    always_comb begin
        grant_vld = 1'b0;
        win       = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= 3) idx = idx - 3;
            if (eligible[idx]) begin
                grant_vld = 1'b1;
                win       = 2'(idx);
            end
        end
    end

    // Data of the winning source.
    always_comb begin
        case (win)
            2'd0:    win_data = itemperature;
            2'd1:    win_data = iautor;
            default: win_data = imusica;
        endcase
    end

    assign commit_en = (state_q == S_COMMIT) && !hold_w;
    assign wrap      = (cnt_q == LAST_CNT);
    assign sel_nxt   = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;

    // Next display registers and field selection; the registered output value
    // is taken from these so the commit is visible the cycle after S_COMMIT.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            disp_d[i] = (commit_en && dirty_q[i]) ? shadow_q[i] : disp_q[i];
        end
        sel_d = (commit_en && wrap) ? sel_nxt : sel_q;
    end

    // Run/commit FSM with arbitration, commit, page counter and output regs.
    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q  <= S_RUN;
            shadow_q <= '0;
            disp_q   <= '0;
            dirty_q  <= '0;
            cnt_q    <= '0;
            rr_q     <= 2'd0;
            sel_q    <= 2'(RESET_SEL);
            ack_q    <= '0;
            upd_q    <= 1'b0;
            val_q    <= '0;
        end else begin
            ack_q <= '0;
            upd_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (iframe_start) begin
                        state_q <= S_COMMIT;
                    end else if (grant_vld) begin
                        shadow_q[win] <= win_data;
                        dirty_q[win]  <= 1'b1;
                        ack_q         <= 3'b001 << win;
                        rr_q          <= (win == 2'd2) ? 2'd0 : win + 2'd1;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    if (commit_en) begin
                        dirty_q <= '0;
                        cnt_q   <= wrap ? '0 : cnt_q + CNT_W'(1);
                        upd_q   <= (|dirty_q) || wrap;
                    end
                end
            endcase
            disp_q <= disp_d;
            sel_q  <= sel_d;
            val_q  <= disp_d[sel_d];
        end
    end

    assign oack           = ack_q;
    assign odisplay_value = val_q;
    assign odisplay_sel   = sel_q;
    assign oupdated       = upd_q;

endmodule

// File: tb/tb_display_field_scheduler.sv
// Self-checking bench for display_field_scheduler (FRAMES_PER_PAGE=3,
// RESET_SEL=1). Frame commits push an expectation to a scoreboard queue that
// is popped when the committed value becomes visible.
module tb_display_field_scheduler;

    localparam int FPP  = 3;
    localparam int RSEL = 1;

    logic        iclock = 1'b0;
    logic        ireset_n;
    logic        iframe_start;
    logic [2:0]  ireq;
    logic [15:0] itemperature, iautor, imusica;
`ifdef DISPLAY_HOLD_EN
    logic        ihold;
`endif
    logic [2:0]  oack;
    logic [15:0] odisplay_value;
    logic [1:0]  odisplay_sel;
    logic        oupdated;

    display_field_scheduler #(
        .FRAMES_PER_PAGE(FPP),
        .CNT_W(8),
        .RESET_SEL(RSEL)
    ) dut (
        .iclock(iclock),
        .ireset_n(ireset_n),
        .iframe_start(iframe_start),
        .ireq(ireq),
        .itemperature(itemperature),
        .iautor(iautor),
        .imusica(imusica),
`ifdef DISPLAY_HOLD_EN
        .ihold(ihold),
`endif
        .oack(oack),
        .odisplay_value(odisplay_value),
        .odisplay_sel(odisplay_sel),
        .oupdated(oupdated)
    );

    always #5 iclock = ~iclock;

    typedef struct {
        logic [15:0] val;
        logic [1:0]  sel;
        logic        upd;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    logic [15:0] mshadow [3];
    logic [15:0] mdisp   [3];
    logic [2:0]  mdirty;
    int          mcnt;
    int          msel;

    task automatic tick();
        @(posedge iclock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mshadow[i] = '0;
            mdisp[i]   = '0;
        end
        mdirty = '0;
        mcnt   = 0;
        msel   = RSEL;
    endtask

    // Reference frame commit: push what the outputs must show afterwards.
    task automatic model_commit(input bit hold);
        exp_t e;
        bit   rot;
        e.upd = 1'b0;
        if (!hold) begin
            rot   = (mcnt == FPP - 1);
            e.upd = (mdirty != 0) || rot;
            for (int i = 0; i < 3; i++)
                if (mdirty[i]) mdisp[i] = mshadow[i];
            mdirty = '0;
            if (rot) begin
                mcnt = 0;
                msel = (msel == 2) ? 0 : msel + 1;
            end else begin
                mcnt = mcnt + 1;
            end
        end
        e.sel = 2'(msel);
        e.val = mdisp[msel];
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (odisplay_value !== e.val) begin
            errors++;
            $display("FAIL %s value: got %h expected %h", name, odisplay_value, e.val);
        end
        checks++;
        if (odisplay_sel !== e.sel) begin
            errors++;
            $display("FAIL %s sel: got %0d expected %0d", name, odisplay_sel, e.sel);
        end
        checks++;
        if (oupdated !== e.upd) begin
            errors++;
            $display("FAIL %s updated: got %b expected %b", name, oupdated, e.upd);
        end
    endtask

    // Pulse iframe_start and verify the commit shows up 2 cycles later.
    task automatic do_frame(input string name, input bit hold);
        model_commit(hold);
        iframe_start = 1'b1;
        tick();
        iframe_start = 1'b0;
        checks++;
        if (oack !== 3'b000 || oupdated !== 1'b0) begin
            errors++;
            $display("FAIL %s commit-cycle: ack %b upd %b expected 000/0", name, oack, oupdated);
        end
        tick();
        pop_compare(name);
        tick();
        checks++;
        if (oupdated !== 1'b0) begin
            errors++;
            $display("FAIL %s upd-pulse-width: got %b expected 0", name, oupdated);
        end
    endtask

    // Producer handshake: hold req until ack, then drop it.
    task automatic grant(input int src, input logic [15:0] d);
        int n = 0;
        case (src)
            0:       itemperature = d;
            1:       iautor       = d;
            default: imusica      = d;
        endcase
        ireq[src] = 1'b1;
        do begin
            tick();
            n++;
        end while (oack !== (3'b001 << src) && n < 20);
        checks++;
        if (oack !== (3'b001 << src)) begin
            errors++;
            $display("FAIL grant src%0d: ack %b expected %b", src, oack, 3'b001 << src);
        end
        ireq[src]    = 1'b0;
        mshadow[src] = d;
        mdirty[src]  = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        ireset_n     = 1'b0;
        iframe_start = 1'b0;
        ireq         = 3'b000;
        itemperature = '0;
        iautor       = '0;
        imusica      = '0;
`ifdef DISPLAY_HOLD_EN
        ihold        = 1'b0;
`endif
        model_reset();
        tick();
        tick();
        checks++;
        if (oack !== 3'b000 || oupdated !== 1'b0 || odisplay_value !== 16'h0 ||
            odisplay_sel !== 2'(RSEL)) begin
            errors++;
            $display("FAIL reset: ack %b upd %b val %h sel %0d expected 000/0/0000/%0d",
                     oack, oupdated, odisplay_value, odisplay_sel, RSEL);
        end
        ireset_n = 1'b1;
        tick();
        checks++;
        if (oack !== 3'b000 || odisplay_sel !== 2'(RSEL)) begin
            errors++;
            $display("FAIL reset-release: ack %b sel %0d", oack, odisplay_sel);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ack [3];
        exp_ack[0] = 3'b001;
        exp_ack[1] = 3'b010;
        exp_ack[2] = 3'b100;
        itemperature = 16'h1111;
        iautor       = 16'h2222;
        imusica      = 16'h3333;
        ireq         = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (oack !== exp_ack[i]) begin
                errors++;
                $display("FAIL rr grant %0d: ack %b expected %b", i, oack, exp_ack[i]);
            end
            ireq[i] = 1'b0;
        end
        mshadow[0] = 16'h1111;
        mshadow[1] = 16'h2222;
        mshadow[2] = 16'h3333;
        mdirty     = 3'b111;
        tick();
        checks++;
        if (oack !== 3'b000 || odisplay_value !== mdisp[msel] || oupdated !== 1'b0) begin
            errors++;
            $display("FAIL rr pre-commit: ack %b val %h upd %b expected 000/%h/0",
                     oack, odisplay_value, oupdated, mdisp[msel]);
        end
        do_frame("rr-commit", 1'b0);
    endtask

    task automatic test_commit_latency();
        grant(0, 16'hAAAA);
        grant(0, 16'h0123);
        grant(1, 16'h4567);
        do_frame("latency-commit", 1'b0);
        do_frame("latency-idle", 1'b0);
    endtask

    task automatic test_req_at_frame();
        model_commit(1'b0);
        iautor       = 16'h89AB;
        ireq[1]      = 1'b1;
        iframe_start = 1'b1;
        tick();
        iframe_start = 1'b0;
        checks++;
        if (oack !== 3'b000) begin
            errors++;
            $display("FAIL req-at-frame pulse-cycle ack: got %b expected 000", oack);
        end
        tick();
        checks++;
        if (oack !== 3'b000) begin
            errors++;
            $display("FAIL req-at-frame commit-cycle ack: got %b expected 000", oack);
        end
        pop_compare("req-at-frame-commit");
        tick();
        checks++;
        if (oack !== 3'b010) begin
            errors++;
            $display("FAIL req-at-frame late ack: got %b expected 010", oack);
        end
        ireq[1]    = 1'b0;
        mshadow[1] = 16'h89AB;
        mdirty[1]  = 1'b1;
        tick();
        do_frame("req-at-frame-next", 1'b0);
    endtask

    task automatic test_rotation();
        for (int f = 0; f < 9; f++) begin
            do_frame($sformatf("rotate%0d", f), 1'b0);
        end
    endtask

`ifdef DISPLAY_HOLD_EN
    task automatic test_hold();
        ihold = 1'b1;
        grant(2, 16'hCAFE);
        do_frame("hold0", 1'b1);
        do_frame("hold1", 1'b1);
        ihold = 1'b0;
        do_frame("hold-release", 1'b0);
    endtask
`endif

    task automatic test_reset_mid();
        int n = 0;
        iautor  = 16'h5A5A;
        ireq[1] = 1'b1;
        do begin
            tick();
            n++;
        end while (oack !== 3'b010 && n < 20);
        checks++;
        if (oack !== 3'b010) begin
            errors++;
            $display("FAIL reset-mid grant: ack %b expected 010", oack);
        end
        ireset_n = 1'b0;
        #1;
        checks++;
        if (oack !== 3'b000 || odisplay_sel !== 2'(RSEL) || odisplay_value !== 16'h0 ||
            oupdated !== 1'b0) begin
            errors++;
            $display("FAIL reset-mid async: ack %b sel %0d val %h upd %b",
                     oack, odisplay_sel, odisplay_value, oupdated);
        end
        ireq[1] = 1'b0;
        model_reset();
        tick();
        ireset_n = 1'b1;
        tick();
        do_frame("reset-mid-dirty-cleared", 1'b0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_commit_latency();
        test_req_at_frame();
        test_rotation();
`ifdef DISPLAY_HOLD_EN
        test_hold();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
